// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, bit-timing helpers and parity.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  function automatic int cpb_of(input int hz, input int baud);
    return hz / baud;
  endfunction

  function automatic int mid_of(input int cpb);
    return (cpb - 1) / 2;
  endfunction

  function automatic logic parity_of(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX line synchroniser, start-edge detect and mid-bit majority-of-3 vote.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int CW           = $clog2(CLKS_PER_BIT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          serial,
  input  logic [CW-1:0] count,
  output logic          fall,
  output logic          maj,
  output logic          strobe
);

  localparam int MID = mid_of(CLKS_PER_BIT);
  localparam logic [CW-1:0] S0 = CW'(MID - 1);
  localparam logic [CW-1:0] S1 = CW'(MID);
  localparam logic [CW-1:0] S2 = CW'(MID + 1);

  logic       s1;
  logic       s2;
  logic       prev;
  logic       armed;
  logic [1:0] settle;
  logic       a;
  logic       b;

  // armed only after a genuine high has crossed the synchroniser,
  // so a line held low out of reset never looks like a start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1     <= 1'b1;
      s2     <= 1'b1;
      prev   <= 1'b1;
      settle <= 2'b00;
      armed  <= 1'b0;
      a      <= 1'b1;
      b      <= 1'b1;
    end else begin
      s1     <= serial;
      s2     <= s1;
      prev   <= s2;
      settle <= {settle[0], 1'b1};
      if (settle[1] && s2)
        armed <= 1'b1;
      if (count == S0)
        a <= s2;
      if (count == S1)
        b <= s2;
    end
  end

  assign fall   = armed & prev & ~s2;
  assign maj    = (a & b) | (a & s2) | (b & s2);
  assign strobe = (count == S2);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with valid/ready delivery and error flags.
// Optional parity slot enabled by defining UART_RX_PARITY_EN.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = 12_000_000,
  parameter int UART_BAUD    = 9600,
  parameter int CLKS_PER_BIT = cpb_of(CLK_HZ, UART_BAUD),
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 SER_CLK,
  input  logic                 RST,
  input  logic                 RX_SERIAL,
  input  logic                 RX_READY,
  output logic                 RX_VALID,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic                 RX_FRAME_ERR,
  output logic                 RX_PARITY_ERR,
  output logic                 RX_BREAK,
  output logic                 RX_OVERRUN,
  output logic                 RX_BUSY
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] NBITS = BW'(DATA_BITS);
  localparam logic [BW-1:0] LSTOP = BW'(STOP_BITS - 1);
`ifdef UART_RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif

  state_t               state;
  state_t               next;
  logic [CW-1:0]        count;
  logic [BW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 ferr_acc;
  logic                 drop;
  logic                 fall;
  logic                 maj;
  logic                 strobe;
  logic                 slot_end;
  logic                 done;
  logic                 ferr;
  logic                 perr;
  logic                 brk;

  uart_rx_sampler #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CW          (CW)
  ) u_smp (
    .clk   (SER_CLK),
    .rst   (RST),
    .serial(RX_SERIAL),
    .count (count),
    .fall  (fall),
    .maj   (maj),
    .strobe(strobe)
  );

  assign slot_end = (count == LAST);
  assign done     = (state == STOP) && strobe && (idx == LSTOP);
  assign ferr     = ferr_acc | ~maj;
  assign RX_BUSY  = (state != IDLE);

`ifdef UART_RX_PARITY_EN
  logic par_bit;

  always_ff @(posedge SER_CLK or posedge RST) begin
    if (RST)
      par_bit <= 1'b0;
    else if (state == PARITY && strobe)
      par_bit <= maj;
  end

  assign perr = parity_of(9'(shreg)) ^ par_bit ^ 1'(PARITY_ODD);
  assign brk  = ferr & ~(|shreg) & ~par_bit;
`else
  logic unused_cfg;
  assign unused_cfg = 1'(PARITY_ODD);
  assign perr       = 1'b0;
  assign brk        = ferr & ~(|shreg);
`endif

  always_ff @(posedge SER_CLK or posedge RST) begin
    if (RST)
      state <= IDLE;
    else
      state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:
        if (fall)
          next = START;
      START:
        if (strobe && maj)
          next = IDLE;
        else if (slot_end)
          next = DATA;
      DATA:
        if (slot_end && idx == NBITS)
          next = AFTER_DATA;
      PARITY:
        if (slot_end)
          next = STOP;
      STOP:
        if (done)
          next = IDLE;
      default:
        next = IDLE;
    endcase
  end

  always_ff @(posedge SER_CLK or posedge RST) begin
    if (RST) begin
      count         <= '0;
      idx           <= '0;
      shreg         <= '0;
      ferr_acc      <= 1'b0;
      drop          <= 1'b0;
      RX_VALID      <= 1'b0;
      RX_DATA       <= '0;
      RX_FRAME_ERR  <= 1'b0;
      RX_PARITY_ERR <= 1'b0;
      RX_BREAK      <= 1'b0;
      RX_OVERRUN    <= 1'b0;
    end else begin
      if (state == IDLE || next == IDLE || slot_end)
        count <= '0;
      else
        count <= count + 1'b1;

      case (state)
        IDLE: begin
          idx      <= '0;
          ferr_acc <= 1'b0;
        end
        DATA: begin
          if (strobe) begin
            shreg <= {maj, shreg[DATA_BITS-1:1]};
            idx   <= idx + 1'b1;
          end else if (slot_end && idx == NBITS) begin
            idx <= '0;
          end
        end
        STOP: begin
          if (strobe) begin
            if (!maj)
              ferr_acc <= 1'b1;
            if (idx != LSTOP)
              idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase

      // a completed frame is kept only if the held word is free or leaving now
      if (done) begin
        if (!RX_VALID || RX_READY) begin
          RX_VALID      <= 1'b1;
          RX_DATA       <= shreg;
          RX_FRAME_ERR  <= ferr;
          RX_PARITY_ERR <= perr;
          RX_BREAK      <= brk;
          RX_OVERRUN    <= drop;
          drop          <= 1'b0;
        end else begin
          drop <= 1'b1;
        end
      end else if (RX_VALID && RX_READY) begin
        RX_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: directed frames, glitches, errors, reset.
module tb_uart_rx_cfg;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int DB  = 7;
  localparam int SB  = 2;
  localparam int PEN = 1;
`else
  localparam int DB  = 8;
  localparam int SB  = 1;
  localparam int PEN = 0;
`endif
  localparam int PODD = 0;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          line  = 1'b1;
  logic          ready = 1'b1;
  logic          valid;
  logic [DB-1:0] data;
  logic          ferr;
  logic          perr;
  logic          brk;
  logic          ovr;
  logic          busy;

  always #5 clk = ~clk;

  uart_rx_cfg #(
    .CLK_HZ      (12_000_000),
    .UART_BAUD   (9600),
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB),
    .STOP_BITS   (SB),
    .PARITY_ODD  (PODD)
  ) dut (
    .SER_CLK      (clk),
    .RST          (rst),
    .RX_SERIAL    (line),
    .RX_READY     (ready),
    .RX_VALID     (valid),
    .RX_DATA      (data),
    .RX_FRAME_ERR (ferr),
    .RX_PARITY_ERR(perr),
    .RX_BREAK     (brk),
    .RX_OVERRUN   (ovr),
    .RX_BUSY      (busy)
  );

  typedef struct {
    logic [8:0] d;
    logic       fe;
    logic       pe;
    logic       br;
    logic       ov;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [8:0] act,
                     input logic [8:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] m(input logic [8:0] d);
    return d & 9'((1 << DB) - 1);
  endfunction

  task automatic push(input logic [8:0] d, input logic fe, input logic pe,
                      input logic br, input logic ov);
    exp_t e;
    e.d  = m(d);
    e.fe = fe;
    e.pe = pe;
    e.br = br;
    e.ov = ov;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_word: got %0h want none", data);
      end else begin
        mon_e = sb.pop_front();
        chk("data", 9'(data), mon_e.d);
        chk("frame_err", 9'(ferr), 9'(mon_e.fe));
        chk("parity_err", 9'(perr), 9'(mon_e.pe));
        chk("break", 9'(brk), 9'(mon_e.br));
        chk("overrun", 9'(ovr), 9'(mon_e.ov));
      end
    end
  end

  task automatic hold(input logic v, input int n);
    line = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 ready = v;
    @(negedge clk);
  endtask

  task automatic send(input logic [8:0] d, input logic pflip,
                      input logic stop0, input int gbit);
    logic p;
    hold(1'b0, CPB);
    for (int i = 0; i < DB; i++) begin
      if (i == gbit) begin
        hold(d[i], 8);
        hold(~d[i], 1);
        hold(d[i], 7);
      end else begin
        hold(d[i], CPB);
      end
    end
    if (PEN != 0) begin
      p = (^m(d)) ^ 1'(PODD) ^ pflip;
      hold(p, CPB);
    end
    for (int i = 0; i < SB; i++)
      hold(~stop0, CPB);
    line = 1'b1;
  endtask

  initial begin
    #12;
    chk("rst_valid", 9'(valid), 9'd0);
    chk("rst_data", 9'(data), 9'd0);
    chk("rst_flags", 9'({ferr, perr, brk, ovr}), 9'd0);
    chk("rst_busy", 9'(busy), 9'd0);
    @(negedge clk);
    rst = 1'b0;
    hold(1'b1, CPB * 2);

    push(9'hA5, 0, 0, 0, 0);
    send(9'hA5, 0, 0, -1);
    hold(1'b1, CPB);
    push(9'h00, 0, 0, 0, 0);
    send(9'h00, 0, 0, -1);
    push(9'hFF, 0, 0, 0, 0);
    send(9'hFF, 0, 0, -1);
    hold(1'b1, CPB * 2);

    hold(1'b0, 3);
    chk("glitch_busy_hi", 9'(busy), 9'd1);
    hold(1'b1, CPB * 2);
    chk("glitch_busy_lo", 9'(busy), 9'd0);

    push(9'hA4, 0, 0, 0, 0);
    send(9'hA4, 0, 0, 0);
    hold(1'b1, CPB * 2);

`ifdef UART_RX_PARITY_EN
    push(9'h41, 0, 0, 0, 0);
    send(9'h41, 0, 0, -1);
    push(9'h41, 0, 1, 0, 0);
    send(9'h41, 1, 0, -1);
    hold(1'b1, CPB * 2);
`endif

    push(9'h55, 1, 0, 0, 0);
    send(9'h55, 0, 1, -1);
    hold(1'b1, CPB * 2);

    push(9'h00, 1, 0, 1, 0);
    hold(1'b0, 2 * (1 + DB + PEN + SB) * CPB);
    hold(1'b1, CPB * 3);

    set_ready(1'b0);
    push(9'h11, 0, 0, 0, 0);
    send(9'h11, 0, 0, -1);
    send(9'h22, 0, 0, -1);
    send(9'h33, 0, 0, -1);
    hold(1'b1, CPB * 2);
    chk("ovr_held_valid", 9'(valid), 9'd1);
    set_ready(1'b1);
    hold(1'b1, CPB);
    push(9'h44, 0, 0, 0, 1);
    send(9'h44, 0, 0, -1);
    hold(1'b1, CPB * 2);

    set_ready(1'b0);
    send(9'h77, 0, 0, -1);
    hold(1'b1, CPB * 2);
    chk("held_valid", 9'(valid), 9'd1);
    chk("held_data", 9'(data), m(9'h77));
    hold(1'b0, CPB);
    hold(1'b0, CPB);
    hold(1'b0, CPB);
    hold(1'b1, CPB);
    hold(1'b1, 5);
    chk("midframe_busy", 9'(busy), 9'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 9'(valid), 9'd0);
    chk("arst_data", 9'(data), 9'd0);
    chk("arst_flags", 9'({ferr, perr, brk, ovr}), 9'd0);
    chk("arst_busy", 9'(busy), 9'd0);
    line = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    hold(1'b0, CPB * 3);
    chk("low_release_busy", 9'(busy), 9'd0);
    chk("low_release_valid", 9'(valid), 9'd0);
    set_ready(1'b1);
    hold(1'b1, CPB * 2);
    push(9'h3C, 0, 0, 0, 0);
    send(9'h3C, 0, 0, -1);
    hold(1'b1, CPB * 4);

    chk("queue_empty", 9'(sb.size()), 9'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
